// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, fetches over a req/ack imem handshake, feeds op/fn to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] id_instr,
    output logic [5:0]  id_op,
    output logic [5:0]  id_fn,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc4;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic [31:0] w_pc4;
    logic [31:0] w_target;
    logic        w_ack;
    logic        w_pc_adv;
    logic        w_buf_fill;
    logic        w_enter_drop;
    logic        w_load;
    logic [31:0] w_ld_instr;
    logic [31:0] w_ld_pc4;
    logic        w_clear;

    assign w_pc4    = r_pc + 32'd4;
    // Low two target bits are masked off so targets are word aligned.
    assign w_target = redirect_pc & 32'hFFFF_FFFC;
    // An ack only counts while a request is actually on the bus.
    assign w_ack    = imem_ack && (r_state != S_HOLD);

    // State register: reset always returns to FETCH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: redirect outranks ack/stall classification.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    w_next_state = w_ack ? S_FETCH : S_DROP;
                end else if (w_ack && stall) begin
                    w_next_state = S_HOLD;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    w_next_state = S_DROP;
                end else if (w_ack) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_DROP;
                end
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Bus outputs: DROP keeps the abandoned address until its ack arrives.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = r_pc;
                end
                S_DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = r_drop_addr;
                end
                default: begin
                    imem_req  = 1'b0;
                    imem_addr = r_pc;
                end
            endcase
        end
    end

    // Datapath controls: what enters IF/ID, when to bubble, when PC moves.
    always_comb begin
        w_pc_adv     = 1'b0;
        w_buf_fill   = 1'b0;
        w_enter_drop = 1'b0;
        w_load       = 1'b0;
        w_ld_instr   = imem_data;
        w_ld_pc4     = w_pc4;
        case (r_state)
            S_FETCH: begin
                w_pc_adv     = w_ack && !redirect;
                w_buf_fill   = w_ack && stall && !redirect;
                w_enter_drop = redirect && !w_ack;
                w_load       = w_ack && !stall && !redirect;
            end
            S_HOLD: begin
                w_load     = !stall && !redirect;
                w_ld_instr = r_buf_instr;
                w_ld_pc4   = r_buf_pc4;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
        // Without a load, IF/ID bubbles unless stall holds it; flush and
        // redirect squash the current occupant regardless of stall.
        w_clear = redirect || (!w_load && (flush || !stall));
    end

    // Program counter: redirect target wins over sequential advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= w_target;
        end else if (w_pc_adv) begin
            r_pc <= w_pc4;
        end
    end

    // Capture the outstanding address when a redirect abandons it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_addr <= 32'h0;
        end else if (w_enter_drop) begin
            r_drop_addr <= r_pc;
        end
    end

    // Skid buffer for a word acked while decode is stalled.
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            r_buf_instr <= 32'h0;
            r_buf_pc4   <= 32'h0;
        end else if (w_buf_fill) begin
            r_buf_instr <= imem_data;
            r_buf_pc4   <= w_pc4;
        end
    end

    // IF/ID register: a fresh load beats flush; bubbles zero the word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id_valid <= 1'b0;
            r_id_instr <= 32'h0;
            r_id_pc4   <= 32'h0;
        end else if (w_load) begin
            r_id_valid <= 1'b1;
            r_id_instr <= w_ld_instr;
            r_id_pc4   <= w_ld_pc4;
        end else if (w_clear) begin
            r_id_valid <= 1'b0;
            r_id_instr <= 32'h0;
        end
    end

    assign id_valid = r_id_valid;
    assign id_instr = r_id_instr;
    assign id_pc4   = r_id_pc4;
    assign id_op    = r_id_instr[31:26];
    assign id_fn    = r_id_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table plus hand sequences.
// Each row drives one cycle and checks outputs seen during that cycle.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [5:0]  id_fn;
    logic [31:0] id_pc4;
    logic        id_valid;

    int checks;
    int failures;

    localparam logic [31:0] IA = 32'h2001_0005;
    localparam logic [31:0] IB = 32'h0022_1820;
    localparam logic [31:0] IC = 32'h1000_0003;
    localparam logic [31:0] ID = 32'h8C22_0004;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] data;
        logic        stl;
        logic        fls;
        logic        rdr;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tv[$];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_instr    (id_instr),
        .id_op       (id_op),
        .id_fn       (id_fn),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic rst, input logic ack, input logic [31:0] data,
        input logic stl, input logic fls, input logic rdr,
        input logic [31:0] rpc, input logic e_req,
        input logic [31:0] e_addr, input logic e_valid,
        input logic [31:0] e_instr, input logic [31:0] e_pc4);
        vec_t v;
        v.rst = rst; v.ack = ack; v.data = data;
        v.stl = stl; v.fls = fls; v.rdr = rdr; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc4 = e_pc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ack,
                         input logic [31:0] data, input logic stl,
                         input logic fls, input logic rdr,
                         input logic [31:0] rpc);
        reset       = rst;
        imem_ack    = ack;
        imem_data   = data;
        stall       = stl;
        flush       = fls;
        redirect    = rdr;
        redirect_pc = rpc;
    endtask

    task automatic check_id(input string tag, input logic e_valid,
                            input logic [31:0] e_instr,
                            input logic [31:0] e_pc4);
        logic [31:0] w;
        w = e_instr;
        chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, e_valid});
        chk({tag, ".instr"}, id_instr, w);
        chk({tag, ".op"}, {26'h0, id_op}, {26'h0, w[31:26]});
        chk({tag, ".fn"}, {26'h0, id_fn}, {26'h0, w[5:0]});
        chk({tag, ".pc4"}, id_pc4, e_pc4);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        //  rst ack data stl fls rdr rpc | req addr valid instr pc4
        // reset cycle
        tv.push_back(mk(1,0,0 ,0,0,0,0, 0,0,0,0,0));
        // zero-wait stream A,B,C
        tv.push_back(mk(0,1,IA,0,0,0,0, 1,32'h0,0,0,0));
        tv.push_back(mk(0,1,IB,0,0,0,0, 1,32'h4,1,IA,32'h4));
        tv.push_back(mk(0,1,IC,0,0,0,0, 1,32'h8,1,IB,32'h8));
        // delayed ack: address held, bubbles
        tv.push_back(mk(0,0,0 ,0,0,0,0, 1,32'hC,1,IC,32'hC));
        tv.push_back(mk(0,0,0 ,0,0,0,0, 1,32'hC,0,0,32'hC));
        tv.push_back(mk(0,0,0 ,0,0,0,0, 1,32'hC,0,0,32'hC));
        tv.push_back(mk(0,1,IA,0,0,0,0, 1,32'hC,0,0,32'hC));
        tv.push_back(mk(0,1,IB,0,0,0,0, 1,32'h10,1,IA,32'h10));
        // stalled ack goes to buffer, HOLD drops req, ack ignored
        tv.push_back(mk(0,1,ID,1,0,0,0, 1,32'h14,1,IB,32'h14));
        tv.push_back(mk(0,0,0 ,1,0,0,0, 0,32'h0,1,IB,32'h14));
        tv.push_back(mk(0,1,IC,1,0,0,0, 0,32'h0,1,IB,32'h14));
        tv.push_back(mk(0,0,0 ,0,0,0,0, 0,32'h0,1,IB,32'h14));
        tv.push_back(mk(0,0,0 ,0,0,0,0, 1,32'h18,1,ID,32'h18));
        // redirect while unacked, then re-redirect inside DROP
        tv.push_back(mk(0,0,0 ,0,0,1,32'h40, 1,32'h18,0,0,32'h18));
        tv.push_back(mk(0,0,0 ,0,0,1,32'h81, 1,32'h18,0,0,32'h18));
        tv.push_back(mk(0,1,IA,0,0,0,0, 1,32'h18,0,0,32'h18));
        tv.push_back(mk(0,1,IB,0,0,0,0, 1,32'h80,0,0,32'h18));
        // redirect to 0x43 same cycle as ack: data dropped
        tv.push_back(mk(0,1,IC,0,0,1,32'h43, 1,32'h84,1,IB,32'h84));
        tv.push_back(mk(0,1,ID,0,0,0,0, 1,32'h40,0,0,32'h84));
        // flush+stall squash; stall holds bubble; load beats flush
        tv.push_back(mk(0,0,0 ,1,1,0,0, 1,32'h44,1,ID,32'h44));
        tv.push_back(mk(0,0,0 ,1,0,0,0, 1,32'h44,0,0,32'h44));
        tv.push_back(mk(0,1,IA,0,1,0,0, 1,32'h44,0,0,32'h44));
        tv.push_back(mk(0,0,0 ,1,0,0,0, 1,32'h48,1,IA,32'h48));
        tv.push_back(mk(0,0,0 ,0,0,0,0, 1,32'h48,1,IA,32'h48));
        // reset while in HOLD: buffer discarded
        tv.push_back(mk(0,1,IB,1,0,0,0, 1,32'h48,0,0,32'h48));
        tv.push_back(mk(1,0,0 ,1,0,0,0, 0,32'h0,0,0,32'h48));
        tv.push_back(mk(0,0,0 ,0,0,0,0, 1,32'h0,0,0,32'h0));
        tv.push_back(mk(0,0,0 ,0,0,0,0, 1,32'h0,0,0,32'h0));
        // reset while in DROP: next ack is taken, not dropped
        tv.push_back(mk(0,0,0 ,0,0,1,32'h100, 1,32'h0,0,0,32'h0));
        tv.push_back(mk(1,0,0 ,0,0,0,0, 0,32'h0,0,0,32'h0));
        tv.push_back(mk(0,1,IC,0,0,0,0, 1,32'h0,0,0,32'h0));
        tv.push_back(mk(0,0,0 ,0,0,0,0, 1,32'h4,1,IC,32'h4));

        @(posedge clock);
        foreach (tv[i]) begin
            @(negedge clock);
            drive(tv[i].rst, tv[i].ack, tv[i].data, tv[i].stl,
                  tv[i].fls, tv[i].rdr, tv[i].rpc);
            #1;
            chk($sformatf("v%0d.req", i), {31'h0, imem_req},
                {31'h0, tv[i].e_req});
            if (tv[i].e_req) begin
                chk($sformatf("v%0d.addr", i), imem_addr, tv[i].e_addr);
            end
            check_id($sformatf("v%0d", i), tv[i].e_valid,
                     tv[i].e_instr, tv[i].e_pc4);
        end

        // PC wraparound: redirect to top word (low bits masked)
        @(negedge clock);
        drive(1'b0, 1'b1, IA, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        #1 chk("wrap.addr0", imem_addr, 32'h4);
        @(negedge clock);
        drive(1'b0, 1'b1, ID, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("wrap.addr1", imem_addr, 32'hFFFF_FFFC);
        check_id("wrap.a", 1'b0, 32'h0, 32'h4);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("wrap.addr2", imem_addr, 32'h0);
        check_id("wrap.b", 1'b1, ID, 32'h0);

        // From reset: ack delayed three cycles, bounded wait for valid
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("dly.rst_req", {31'h0, imem_req}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            chk($sformatf("dly.req%0d", k), {31'h0, imem_req}, 32'h1);
            chk($sformatf("dly.addr%0d", k), imem_addr, 32'h0);
            chk($sformatf("dly.valid%0d", k), {31'h0, id_valid}, 32'h0);
        end
        @(negedge clock);
        drive(1'b0, 1'b1, IB, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("dly.addr_ack", imem_addr, 32'h0);
        chk("dly.valid_ack", {31'h0, id_valid}, 32'h0);
        begin
            int waited;
            waited = 0;
            @(negedge clock);
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            while (!id_valid && waited < 4) begin
                @(negedge clock);
                #1;
                waited++;
            end
            chk("dly.wait_cycles", waited, 0);
            check_id("dly.out", 1'b1, IB, 32'h4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
